// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Load-use stall, branch flush and operand-forwarding select
//            generation for an in-order pipeline.  Tracks DEPTH in-flight
//            instructions behind ID (slot 0 = EX, 1 = MEM, 2 = WB, ...).
// Ports    : clk_i, rst_i (async, active-low)
//            id_*      - ID-stage instruction fields
//            br_taken_i- branch resolved taken in MEM
//            stall_o   - hold PC and IF/ID, bubble into ID/EX
//            flush_o   - squash IF/ID and ID/EX
//            ex_fwd_a_o/ex_fwd_b_o - registered operand selects for EX
//                        (0 = register file, k = slot k-1 output register)
//            stall_cnt_o/flush_cnt_o - saturating 16-bit event counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int AW          = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1,
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_uses_rs_i,
    input  logic          id_uses_rt_i,
    input  logic [AW-1:0] id_dst_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic          br_taken_i,
    output logic          stall_o,
    output logic          flush_o,
    output logic [SW-1:0] ex_fwd_a_o,
    output logic [SW-1:0] ex_fwd_b_o,
    output logic [15:0]   stall_cnt_o,
    output logic [15:0]   flush_cnt_o
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // In-flight slot state
    logic [DEPTH-1:0] valid_q,    valid_d;
    logic [DEPTH-1:0] regwrite_q, regwrite_d;
    logic [DEPTH-1:0] memread_q,  memread_d;
    logic [AW-1:0]    dst_q [DEPTH];
    logic [AW-1:0]    dst_d [DEPTH];

    logic [SW-1:0]    fwd_a_q, fwd_a_d;
    logic [SW-1:0]    fwd_b_q, fwd_b_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [15:0]      flush_cnt_q, flush_cnt_d;

    logic [DEPTH-1:0] match_rs;
    logic [DEPTH-1:0] match_rt;
    logic             load_hazard;
    logic             id_accept;
    logic [SW-1:0]    sel_rs;
    logic [SW-1:0]    sel_rt;

    // A slot matches a source when it will write that register; $0 never
    // matches since it is hard-wired to zero.
    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        assign match_rs[k] = valid_q[k] & regwrite_q[k] &
                             (dst_q[k] == id_rs_i) & (id_rs_i != '0);
        assign match_rt[k] = valid_q[k] & regwrite_q[k] &
                             (dst_q[k] == id_rt_i) & (id_rt_i != '0);
    end

    // Load-use hazard: a load that has not yet reached a slot able to
    // forward its data.
    always_comb begin
        load_hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (memread_q[k] &&
                ((id_uses_rs_i && match_rs[k]) || (id_uses_rt_i && match_rt[k])))
                load_hazard = 1'b1;
        end
    end

    // Branch flush outranks the stall: the stalled instruction is squashed.
    assign flush_o   = br_taken_i;
    assign stall_o   = id_valid_i & ~br_taken_i & load_hazard;
    assign id_accept = id_valid_i & ~stall_o & ~br_taken_i;

    // Forward selects. The select is registered, so a producer seen in slot k
    // now sits in slot k+1 when the consumer is in EX. Scanning from the
    // oldest slot down lets the youngest producer win.
    always_comb begin
        sel_rs = '0;
        sel_rt = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_uses_rs_i && match_rs[k])
                sel_rs = SW'(k + 1);
            if (id_uses_rt_i && match_rt[k])
                sel_rt = SW'(k + 1);
        end
    end

    // Next-state: shift the slot chain, inject ID or a bubble into slot 0,
    // and invalidate the younger slots behind a taken branch.
    always_comb begin
        valid_d[0]    = id_accept;
        regwrite_d[0] = id_accept & id_regwrite_i;
        memread_d[0]  = id_accept & id_memread_i;
        dst_d[0]      = id_accept ? id_dst_i : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]    = valid_q[k-1];
            regwrite_d[k] = regwrite_q[k-1];
            memread_d[k]  = memread_q[k-1];
            dst_d[k]      = dst_q[k-1];
            if (br_taken_i && (k <= FLUSH_SLOTS))
                valid_d[k] = 1'b0;
        end

        fwd_a_d = id_accept ? sel_rs : '0;
        fwd_b_d = id_accept ? sel_rt : '0;

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != C_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;

        flush_cnt_d = flush_cnt_q;
        if (flush_o && (flush_cnt_q != C_CNT_MAX))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            memread_q   <= '0;
            for (int k = 0; k < DEPTH; k++)
                dst_q[k] <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            for (int k = 0; k < DEPTH; k++)
                dst_q[k] <= dst_d[k];
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_fwd_a_o  = fwd_a_q;
    assign ex_fwd_b_o  = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Directed self-checking bench for pipe_hazard_unit. Instance u1
//            uses default parameters; u2 uses DEPTH=4, LOAD_LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- instance 1: default parameters ----------------
    logic        rst1;
    logic        v1, urs1, urt1, rw1, mr1, br1;
    logic [4:0]  rs1, rt1, dst1;
    logic        stall1, flush1;
    logic [1:0]  fa1, fb1;
    logic [15:0] sc1, fc1;

    pipe_hazard_unit u1 (
        .clk_i(clk), .rst_i(rst1), .id_valid_i(v1),
        .id_rs_i(rs1), .id_rt_i(rt1), .id_uses_rs_i(urs1), .id_uses_rt_i(urt1),
        .id_dst_i(dst1), .id_regwrite_i(rw1), .id_memread_i(mr1),
        .br_taken_i(br1), .stall_o(stall1), .flush_o(flush1),
        .ex_fwd_a_o(fa1), .ex_fwd_b_o(fb1),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    // ---------------- instance 2: DEPTH=4, LOAD_LAT=2 ----------------
    logic        rst2;
    logic        v2, urs2, urt2, rw2, mr2, br2;
    logic [4:0]  rs2, rt2, dst2;
    logic        stall2, flush2;
    logic [2:0]  fa2, fb2;
    logic [15:0] sc2, fc2;

    pipe_hazard_unit #(.AW(5), .DEPTH(4), .LOAD_LAT(2), .FLUSH_SLOTS(1)) u2 (
        .clk_i(clk), .rst_i(rst2), .id_valid_i(v2),
        .id_rs_i(rs2), .id_rt_i(rt2), .id_uses_rs_i(urs2), .id_uses_rt_i(urt2),
        .id_dst_i(dst2), .id_regwrite_i(rw2), .id_memread_i(mr2),
        .br_taken_i(br2), .stall_o(stall2), .flush_o(flush2),
        .ex_fwd_a_o(fa2), .ex_fwd_b_o(fb2),
        .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    // Advance one clock; leave time just past the edge for driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id1(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt,
                           input logic [4:0] dst, input logic rw, input logic mr);
        v1 = v; rs1 = rs; urs1 = urs; rt1 = rt; urt1 = urt;
        dst1 = dst; rw1 = rw; mr1 = mr;
    endtask

    task automatic set_id2(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt,
                           input logic [4:0] dst, input logic rw, input logic mr);
        v2 = v; rs2 = rs; urs2 = urs; rt2 = rt; urt2 = urt;
        dst2 = dst; rw2 = rw; mr2 = mr;
    endtask

    task automatic drain1();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        br1 = 1'b0;
        repeat (3) step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst1 = 1'b0; rst2 = 1'b0; br1 = 1'b0; br2 = 1'b0;
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        set_id2(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd0) $display("FAIL reset_fwd: got a=%0d b=%0d expected 0 0", fa1, fb1); else pass_cnt++;
        total_cnt++; if (sc1 !== 16'd0 || fc1 !== 16'd0) $display("FAIL reset_cnt: got s=%0d f=%0d expected 0 0", sc1, fc1); else pass_cnt++;
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", stall1); else pass_cnt++;
        br1 = 1'b1; #1;
        total_cnt++; if (flush1 !== 1'b1) $display("FAIL reset_flush_follow: got %0b expected 1", flush1); else pass_cnt++;
        br1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1; rst2 = 1'b1;
        step();
    endtask

    // add $3 ; add $4,$3,$5 back-to-back
    task automatic test_fwd_ex();
        drain1();
        set_id1(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        step();
        set_id1(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0);
        #1;
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL fwd_ex_nostall: got %0b expected 0", stall1); else pass_cnt++;
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd1 || fb1 !== 2'd0) $display("FAIL fwd_ex_sel: got a=%0d b=%0d expected 1 0", fa1, fb1); else pass_cnt++;
    endtask

    // lw $2 ; add $6,$2,$2
    task automatic test_load_use();
        drain1();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1);
        step();
        set_id1(1, 5'd2, 1, 5'd2, 1, 5'd6, 1, 0);
        #1;
        total_cnt++; if (stall1 !== 1'b1) $display("FAIL load_use_stall: got %0b expected 1", stall1); else pass_cnt++;
        step();
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL load_use_stall_end: got %0b expected 0", stall1); else pass_cnt++;
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd0) $display("FAIL load_use_bubble_sel: got a=%0d b=%0d expected 0 0", fa1, fb1); else pass_cnt++;
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd2 || fb1 !== 2'd2) $display("FAIL load_use_sel: got a=%0d b=%0d expected 2 2", fa1, fb1); else pass_cnt++;
        total_cnt++; if (sc1 !== 16'd1) $display("FAIL load_use_cnt: got %0d expected 1", sc1); else pass_cnt++;
    endtask

    // Two writers of $7; the younger one must be selected.
    task automatic test_youngest();
        drain1();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0);
        step();
        set_id1(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 0);
        step();
        set_id1(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd1 || fb1 !== 2'd1) $display("FAIL youngest_sel: got a=%0d b=%0d expected 1 1", fa1, fb1); else pass_cnt++;
    endtask

    // A load targeting $0 must neither forward nor stall.
    task automatic test_zero_reg();
        drain1();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
        step();
        set_id1(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0);
        #1;
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL zero_reg_stall: got %0b expected 0", stall1); else pass_cnt++;
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd0) $display("FAIL zero_reg_sel: got a=%0d b=%0d expected 0 0", fa1, fb1); else pass_cnt++;
    endtask

    // Unused sources neither forward nor stall.
    task automatic test_unused_src();
        drain1();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 0);   // add $9
        step();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1);  // lw $10
        step();
        set_id1(1, 5'd10, 0, 5'd9, 1, 5'd11, 1, 0); // rs=$10 unused, rt=$9
        #1;
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL unused_src_stall: got %0b expected 0", stall1); else pass_cnt++;
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd2) $display("FAIL unused_src_sel: got a=%0d b=%0d expected 0 2", fa1, fb1); else pass_cnt++;
    endtask

    // Branch taken in the same cycle as a load-use condition.
    task automatic test_branch();
        drain1();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 0);  // add $11
        step();
        set_id1(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1);  // lw $12
        step();
        set_id1(1, 5'd12, 1, 5'd11, 1, 5'd13, 1, 0);
        br1 = 1'b1;
        #1;
        total_cnt++; if (stall1 !== 1'b0 || flush1 !== 1'b1) $display("FAIL branch_prio: got stall=%0b flush=%0b expected 0 1", stall1, flush1); else pass_cnt++;
        step();
        br1 = 1'b0;
        total_cnt++; if (fc1 !== 16'd1 || sc1 !== 16'd1) $display("FAIL branch_cnt: got f=%0d s=%0d expected 1 1", fc1, sc1); else pass_cnt++;
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd0) $display("FAIL branch_bubble_sel: got a=%0d b=%0d expected 0 0", fa1, fb1); else pass_cnt++;
        // $13 would be in slot 0 and $12 in slot 1 had they not been squashed.
        set_id1(1, 5'd13, 1, 5'd12, 1, 5'd14, 1, 0);
        #1;
        total_cnt++; if (stall1 !== 1'b0) $display("FAIL branch_after_stall: got %0b expected 0", stall1); else pass_cnt++;
        step();
        set_id1(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa1 !== 2'd0 || fb1 !== 2'd0) $display("FAIL branch_slots_invalid: got a=%0d b=%0d expected 0 0", fa1, fb1); else pass_cnt++;
    endtask

    // DEPTH=4, LOAD_LAT=2: two-cycle stall, then reset asserted mid-stall.
    task automatic test_depth4();
        set_id2(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1);   // lw $2
        step();
        set_id2(1, 5'd2, 1, 5'd2, 1, 5'd6, 1, 0);   // add $6,$2,$2
        #1;
        total_cnt++; if (stall2 !== 1'b1) $display("FAIL d4_stall_c1: got %0b expected 1", stall2); else pass_cnt++;
        step();
        total_cnt++; if (stall2 !== 1'b1) $display("FAIL d4_stall_c2: got %0b expected 1", stall2); else pass_cnt++;
        step();
        total_cnt++; if (stall2 !== 1'b0) $display("FAIL d4_stall_end: got %0b expected 0", stall2); else pass_cnt++;
        step();
        set_id2(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa2 !== 3'd3 || fb2 !== 3'd3) $display("FAIL d4_sel: got a=%0d b=%0d expected 3 3", fa2, fb2); else pass_cnt++;
        total_cnt++; if (sc2 !== 16'd2) $display("FAIL d4_stall_cnt: got %0d expected 2", sc2); else pass_cnt++;
        step();
        set_id2(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);   // lw $4
        step();
        set_id2(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0);   // consumer of $4
        #1;
        total_cnt++; if (stall2 !== 1'b1) $display("FAIL d4_restall: got %0b expected 1", stall2); else pass_cnt++;
        step();
        rst2 = 1'b0;
        #1;
        total_cnt++; if (stall2 !== 1'b0) $display("FAIL d4_rst_stall: got %0b expected 0", stall2); else pass_cnt++;
        total_cnt++; if (fa2 !== 3'd0 || fb2 !== 3'd0 || sc2 !== 16'd0 || fc2 !== 16'd0)
            $display("FAIL d4_rst_outputs: got a=%0d b=%0d s=%0d f=%0d expected all 0", fa2, fb2, sc2, fc2); else pass_cnt++;
        #1;
        rst2 = 1'b1;
        step();
        set_id2(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++; if (fa2 !== 3'd0 || fb2 !== 3'd0) $display("FAIL d4_post_rst_sel: got a=%0d b=%0d expected 0 0", fa2, fb2); else pass_cnt++;
    endtask

    // Flush counter saturates at 16'hFFFF; stall counter untouched meanwhile.
    task automatic test_saturate();
        drain1();
        br1 = 1'b1;
        for (int i = 0; i < 65540; i++)
            @(posedge clk);
        #1;
        total_cnt++; if (fc1 !== 16'hFFFF) $display("FAIL flush_cnt_sat: got %0h expected ffff", fc1); else pass_cnt++;
        step();
        total_cnt++; if (fc1 !== 16'hFFFF || sc1 !== 16'd1) $display("FAIL cnt_hold: got f=%0h s=%0d expected ffff 1", fc1, sc1); else pass_cnt++;
        br1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_unused_src();
        test_branch();
        test_depth4();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
